// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures a/b on start, adds LSB-first through an external carry flop.
// Latency: done pulses WIDTH+1 cycles after the start edge; sum/cout hold until the next accepted start.
// Backpressure: none; start is only sampled in IDLE and ignored while busy. Optional macro: SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             carry_d,
  output logic             carry_en,
  input  logic             carry_q
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             s_bit;
  logic             maj_bit;
  logic             sub_sel;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // One full-adder slice on the current LSBs and the externally held carry.
  always_comb begin
    s_bit   = sa_q[0] ^ sb_q[0] ^ carry_q;
    maj_bit = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
  end

  // Next-state, datapath updates and carry-flop controls; reset forces a carry clear.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    carry_d  = 1'b0;
    carry_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          sb_d     = sub_sel ? ~b : b;
          res_d    = '0;
          cnt_d    = '0;
          carry_en = 1'b1;
          carry_d  = sub_sel;
          state_d  = ADD;
        end
      end
      ADD: begin
        carry_en = 1'b1;
        carry_d  = maj_bit;
        res_d    = {s_bit, res_q[WIDTH-1:1]};
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Publish on DONE entry so sum/cout are valid in the done cycle;
          // maj_bit is exactly what carry_q will hold during DONE.
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = maj_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      carry_en = 1'b1;
      carry_d  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed operations, a cycle-level result model and an external carry flop.
// Latency: expects done WIDTH+1 cycles after the accepted start edge.
// Backpressure: start while busy must be ignored; held start must be accepted every WIDTH+2 cycles.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         carry_d;
  logic         carry_en;
  logic         carry_q_r = 1'b1;  // starts set so reset must clear it

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .carry_d  (carry_d),
    .carry_en (carry_en),
    .carry_q  (carry_q_r)
  );

  // External carry flip-flop (d_flipflop behaviour).
  always @(posedge clk) begin
    if (carry_en) carry_q_r <= carry_d;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: phase 0 = idle, 1..W = computing, W+1 = done cycle.
  int           m_phase = 0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic [W:0]   m_pend  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_pend  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
        m_phase = 1;
      end
    end else if (m_phase == W) begin
      m_phase          = W + 1;
      {m_cout, m_sum}  = m_pend;
    end else if (m_phase == W + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_en;
    exp_en = reset ? 1'b1 :
             ((m_phase >= 1 && m_phase <= W) ? 1'b1 :
             ((m_phase == 0 && start) ? 1'b1 : 1'b0));
    check("busy", busy, (m_phase != 0));
    check("done", done, (m_phase == W + 1));
    check("sum", sum, m_sum);
    check("cout", cout, m_cout);
    check("carry_en", carry_en, exp_en);
    if (reset || m_phase == 0)
      check("carry_d_idle", carry_d, (!reset && start) ? sub : 1'b0);
    if (!reset && m_phase == W + 1)
      check("carry_q_done", carry_q_r, m_cout);
  end

  // One operation from idle with literal expectations on result, latency and busy length.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    @(posedge clk); #1;
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({name, "_done_seen"}, (lat != 0), 1);
    check({name, "_latency"}, lat, W + 1);
    check({name, "_busy_cycles"}, busy_cnt, W + 1);
    check({name, "_sum"}, sum, exp_sum);
    check({name, "_cout"}, cout, exp_cout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    int last_done;
    int cyc;
    logic [W-1:0] got_sum;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset_carry_en", carry_en, 1);
    check("reset_carry_d", carry_d, 0);
    check("reset_busy", busy, 0);
    check("reset_sum", sum, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_carry_en", carry_en, 0);
    check("idle_carry_q", carry_q_r, 0);

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("add_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Start pulsed mid-computation with other operands must be ignored.
    @(posedge clk); #1;
    a = 8'h21; b = 8'h43; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'hEE; b = 8'hEE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    got_sum  = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        got_sum = sum;
      end
    end
    check("ignore_done_count", done_cnt, 1);
    check("ignore_sum", got_sum, 8'h64);

    // Reset during the fourth computing cycle.
    @(posedge clk); #1;
    a = 8'h77; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_sum", sum, 0);
    check("midreset_cout", cout, 0);
    check("midreset_carry_q", carry_q_r, 0);
    run_op("add_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Start held high: accepted every W+2 cycles, operands change every cycle.
    done_cnt  = 0;
    last_done = -1;
    cyc       = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 44; i++) begin
      a = 8'(i * 37 + 5);
      b = 8'(i * 91 + 200);
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last_done >= 0) check("b2b_interval", cyc - last_done, W + 2);
        last_done = cyc;
        done_cnt++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("b2b_done_count", (done_cnt >= 3), 1);
    for (int i = 0; i < W + 3; i++) @(posedge clk);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    run_op("add_after_sub", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder datapath and controller that sits directly upstream of the carry flip-flop (`d_flipflop`) in the serial adder. It captures two parallel operands on a start strobe, shifts them LSB-first through a one-bit full adder over WIDTH cycles, and drives the external carry register's `d` and `enable` while reading back its `out`. The assembled sum and final carry are presented in parallel with a one-cycle done pulse.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2 to 32.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A; sampled on the accepted start edge.
- `b`  in  WIDTH  operand B; sampled on the accepted start edge.
- `sub`  in  1  subtract select; present only with `SERIAL_ADD_SUB_EN`; sampled with `a`/`b`.
- `busy`  out  1  high from the cycle after start acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid from this cycle on.
- `sum`  out  WIDTH  result; holds until the next accepted start.
- `cout`  out  1  final carry out.
- `carry_d`  out  1  to carry flip-flop `d`.
- `carry_en`  out  1  to carry flip-flop `enable`.
- `carry_q`  in  1  from carry flip-flop `out`.

## Operation
- FSM states: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE:
  - `start=1` loads shift registers `sa<=a` and `sb<=b`, clears bit counter `cnt` and the result shift register, and goes to ADD.
  - `carry_en=1` with `carry_d=0` on that edge, which clears the external carry.
  - Otherwise `carry_en=0`.
- ADD, each cycle:
  - `s = sa[0]^sb[0]^carry_q`.
  - `carry_d = maj(sa[0], sb[0], carry_q)`, `carry_en=1`.
  - The result shift register shifts right with `s` entering the MSB. `sa`/`sb` shift right with zero fill. `cnt` increments.
  - When `cnt==WIDTH-1`, go to DONE.
- DONE:
  - `done=1`, `busy=1`, `carry_en=0`.
  - `sum` gets the result register; `cout` gets `carry_q`.
  - Go to IDLE next cycle.
- `start` in ADD or DONE is ignored: no queueing, operands are not re-sampled.
- Arithmetic is modulo 2^WIDTH. `{cout,sum}` equals `a+b`, a (WIDTH+1)-bit exact result.
- `carry_d`/`carry_en` are combinational from state, `sa[0]`, `sb[0]` and `carry_q`. There is no combinational loop because `carry_q` is registered externally.
- Reset, including mid-operation, returns to IDLE with `sum=0`, `cout=0`, `busy=0`, `done=0`, and `cnt`/`sa`/`sb` cleared. While `reset=1`, `carry_en=1` and `carry_d=0`, so the external carry also clears synchronously.

## Timing
- Start accepted at edge E0. ADD occupies cycles E0..E0+WIDTH (WIDTH edges). DONE is the cycle after edge E0+WIDTH, so `done` is high WIDTH+1 cycles after the start edge. IDLE resumes one cycle later.
- Minimum start-to-start interval is WIDTH+2 cycles.
- `busy` rises the cycle after E0 and falls with the IDLE return.
- `sum`/`cout` update only on entry to DONE and are stable otherwise.
- Reset values: `busy=0`, `done=0`, `sum=0`, `cout=0`. During reset, `carry_en=1` and `carry_d=0`. Out of reset in IDLE, `carry_en=0` and `carry_d=0`.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - The `sub` port exists.
  - When `sub=1` at start, `sb` loads `~b` and the start edge drives `carry_d=1`, so the result is `a-b` mod 2^WIDTH.
  - `cout=1` means no borrow.
- `SERIAL_ADD_SUB_EN` undefined: no `sub` port; addition only; the start edge always clears the carry.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start at E0 → `done` high 9 cycles later, `sum=0x96`, `cout=0`, `busy` high for 9 cycles.
- a=0xFF, b=0x01 → `sum=0x00`, `cout=1`. A following run with a=0x01, b=0x01 yields `sum=0x02`, `cout=0`, proving the carry clears at start.
- `start` pulsed during ADD cycle 3 with different operands → ignored; original result returned; `done` pulses once.
- `reset` asserted at ADD cycle 4 → next cycle IDLE, `busy=0`, `sum=0`, `cout=0`, carry flip-flop `out=0`. A new start then returns a correct 0x12+0x34=0x46.
- Back-to-back: start held high continuously → runs accepted every 10 cycles (WIDTH+2); each `done` carries the matching sum.
- With `SERIAL_ADD_SUB_EN`, sub=1, a=0x10, b=0x01 → `sum=0x0F`, `cout=1`. a=0x01, b=0x02 → `sum=0xFF`, `cout=0`.
